hf_reader_sequencer: RTL and testbench
======================================

HF_READER_SEQUENCER -- requirements
Module: hf_reader_sequencer

Interface
REQ-001 SHALL have parameter SLOT_TICKS, default 16; osc_clk cycles per bit slot (one 847.5 kHz subcarrier period at the ADC clock).
REQ-002 SHALL have parameter END_SLOTS, default 2; consecutive unmodulated slots that end a received frame.
REQ-003 SHALL have port osc_clk, input, 1: the only clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high.
REQ-005 SHALL have port start, input, 1: one-cycle request to run one transaction.
REQ-006 SHALL have port tx_len, input, 10: number of bits to transmit, 1..1023; sampled on accepted start.
REQ-007 SHALL have port guard_slots, input, 8: carrier-on slots between TX end and LISTEN start; sampled on accepted start.
REQ-008 SHALL have port rx_timeout, input, 12: slots allowed in LISTEN before the first modulated slot; sampled on accepted start.
REQ-009 SHALL have port tx_data, input, 8: next TX byte, transmitted LSB first.
REQ-010 SHALL have port tx_valid, input, 1: tx_data is valid.
REQ-011 SHALL have port tx_ready, output, 1: byte is taken in this cycle when tx_valid is also high.
REQ-012 SHALL have port curbit, input, 1: per-slot modulation decision from the demodulator.
REQ-013 SHALL have port mod_type, output, 3: HF mode select (000 off, 011 reader listen, 100 reader mod).
REQ-014 SHALL have port mod_sig, output, 1: 1 = carrier pause, valid only in reader mod.
REQ-015 SHALL have port rx_bit and rx_bit_valid, output, 1 each: received slot value plus a one-cycle strobe.
REQ-016 SHALL have port busy, output, 1: high from the cycle after an accepted start until done.
REQ-017 SHALL have port done, output, 1: one-cycle end-of-transaction strobe.
REQ-018 SHALL have port status, output, 2: 0 ok, 1 rx timeout, 2 tx underrun; valid with done, held until the next start.

Function
REQ-019 SHALL implement the states IDLE, LOAD, TX, GUARD, LISTEN, RX and FIN.
REQ-020 SHALL accept start only in IDLE; start in any other state is ignored.
REQ-021 SHALL reload a slot phase counter (0..SLOT_TICKS-1) to 0 on every state entry; all slot decisions occur at phase SLOT_TICKS-1.
REQ-022 IDLE: mod_type=000, mod_sig=0, tx_ready=0; accepted start -> LOAD next cycle with the config latched.
REQ-023 LOAD: tx_ready=1; the byte is taken when tx_valid=1, then -> TX; if tx_valid stays 0 for SLOT_TICKS cycles -> FIN with status=2.
REQ-024 TX: mod_type=100; mod_sig = current bit for the whole slot, registered, changing only at phase 0.
REQ-025 TX: SHALL decrement the bit counter at each slot end; at 0 -> GUARD.
REQ-026 TX: after bit 7 of a byte with bits remaining, SHALL assert tx_ready during that slot's last cycle; if no handshake occurs -> FIN with status=2 and mod_sig forced to 0.
REQ-027 GUARD: mod_type=011, mod_sig=0 for guard_slots slots; guard_slots=0 -> LISTEN after one cycle.
REQ-028 LISTEN: mod_type=011; each slot end samples curbit; curbit=1 -> RX with rx_bit=1 and rx_bit_valid pulsed.
REQ-029 LISTEN: after rx_timeout slots with no curbit=1 -> FIN with status=1; rx_timeout=0 SHALL mean 4096 slots.
REQ-030 RX: mod_type=011; each slot end outputs rx_bit=curbit with rx_bit_valid pulsed.
REQ-031 RX: a zero-run counter SHALL clear on curbit=1; reaching END_SLOTS -> FIN with status=0; the trailing zero slots are still output.
REQ-032 FIN: done=1 for one cycle, mod_type=000, then -> IDLE; busy SHALL drop in the same cycle done rises.
REQ-033 All outputs SHALL be registered; mod_type changes only at state transitions.

Reset
REQ-034 reset SHALL force IDLE, mod_type=000, mod_sig=0, tx_ready=0, rx_bit=0, rx_bit_valid=0, busy=0, done=0, status=0, and clear all counters.
REQ-035 reset mid-transaction SHALL abort without a done pulse; reset has priority over start.

Verification
REQ-036 start with tx_len=7, byte 0x26, guard 2, then a curbit pattern 1,0,1,1,0,0 -> mod_sig 0,1,1,0,0,1,0 per 16-cycle slot; 2 guard slots; rx_bit 1,0,1,1,0,0; done with status 0.
REQ-037 tx_len=16, tx_valid withheld for the 2nd byte -> FIN after 8 slots, mod_sig=0, status=2.
REQ-038 rx_timeout=5 with curbit held 0 -> done 5 slots after LISTEN entry, status=1, no rx_bit_valid.
REQ-039 start pulsed again while busy -> ignored; the transaction completes unchanged.
REQ-040 reset asserted in TX slot 3 -> next cycle mod_type=000, busy=0, no done; a following start runs normally.

Source files
------------

// File: rtl/hf_reader_sequencer_if.sv
// Reader-side bus between the HF transaction controller and its host/demodulator.
// Host supplies config, TX bytes and the per-slot demod decision; the sequencer returns modulation controls, RX bits and status.
interface hf_reader_sequencer_if;
    localparam int unsigned LEN_W  = 10;
    localparam int unsigned GRD_W  = 8;
    localparam int unsigned TO_W   = 12;
    localparam int unsigned BYTE_W = 8;

    logic              start;
    logic [LEN_W-1:0]  tx_len;
    logic [GRD_W-1:0]  guard_slots;
    logic [TO_W-1:0]   rx_timeout;
    logic [BYTE_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              curbit;
    logic [2:0]        mod_type;
    logic              mod_sig;
    logic              rx_bit;
    logic              rx_bit_valid;
    logic              busy;
    logic              done;
    logic [1:0]        status;

    modport master (
        output start, tx_len, guard_slots, rx_timeout, tx_data, tx_valid, curbit,
        input  tx_ready, mod_type, mod_sig, rx_bit, rx_bit_valid, busy, done, status
    );

    modport slave (
        input  start, tx_len, guard_slots, rx_timeout, tx_data, tx_valid, curbit,
        output tx_ready, mod_type, mod_sig, rx_bit, rx_bit_valid, busy, done, status
    );
endinterface

// File: rtl/hf_reader_sequencer.sv
// HF reader transaction sequencer: transmit tx_len bits as carrier pauses, wait a guard gap,
// then listen for the tag response slot by slot until an end-of-frame zero run or a timeout.
module hf_reader_sequencer #(
    parameter int unsigned SLOT_TICKS = 16,
    parameter int unsigned END_SLOTS  = 2
) (
    input logic                    osc_clk,
    input logic                    reset,
    hf_reader_sequencer_if.slave   bus
);
    localparam int unsigned PH_W = (SLOT_TICKS > 1) ? $clog2(SLOT_TICKS) : 1;
    localparam int unsigned ZR_W = $clog2(END_SLOTS + 1);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(SLOT_TICKS - 1);
    localparam logic [ZR_W-1:0] ZR_END  = ZR_W'(END_SLOTS);

    localparam logic [2:0] MT_OFF    = 3'b000;
    localparam logic [2:0] MT_LISTEN = 3'b011;
    localparam logic [2:0] MT_MOD    = 3'b100;

    localparam logic [1:0] ST_OK       = 2'd0;
    localparam logic [1:0] ST_TIMEOUT  = 2'd1;
    localparam logic [1:0] ST_UNDERRUN = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_TX, S_GUARD, S_LISTEN, S_RX, S_FIN
    } state_e;

    state_e          state_q, state_d;
    logic [PH_W-1:0] phase_q, phase_d;
    logic [9:0]      bits_q, bits_d;
    logic [7:0]      shreg_q, shreg_d;
    logic [2:0]      bitidx_q, bitidx_d;
    logic [7:0]      guard_cnt_q, guard_cnt_d;
    logic [11:0]     to_cnt_q, to_cnt_d;
    logic [ZR_W-1:0] zrun_q, zrun_d;
    logic [7:0]      cfg_guard_q, cfg_guard_d;
    logic [11:0]     cfg_to_q, cfg_to_d;
    logic            tx_ready_q, tx_ready_d;
    logic [2:0]      mod_type_q, mod_type_d;
    logic            mod_sig_q, mod_sig_d;
    logic            rx_bit_q, rx_bit_d;
    logic            rx_bit_valid_q, rx_bit_valid_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [1:0]      status_q, status_d;
    logic            slot_end_c;

    assign slot_end_c = (phase_q == PH_LAST);

    // Next-state, counters and registered-output values
    always_comb begin
        state_d        = state_q;
        bits_d         = bits_q;
        shreg_d        = shreg_q;
        bitidx_d       = bitidx_q;
        guard_cnt_d    = guard_cnt_q;
        to_cnt_d       = to_cnt_q;
        zrun_d         = zrun_q;
        cfg_guard_d    = cfg_guard_q;
        cfg_to_d       = cfg_to_q;
        mod_sig_d      = mod_sig_q;
        rx_bit_d       = rx_bit_q;
        rx_bit_valid_d = 1'b0;
        status_d       = status_q;
        phase_d        = phase_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d     = S_LOAD;
                    bits_d      = bus.tx_len;
                    cfg_guard_d = bus.guard_slots;
                    cfg_to_d    = bus.rx_timeout;
                    status_d    = ST_OK;
                end
            end
            S_LOAD: begin
                if (tx_ready_q && bus.tx_valid) begin
                    state_d   = S_TX;
                    shreg_d   = bus.tx_data;
                    bitidx_d  = 3'd0;
                    mod_sig_d = bus.tx_data[0];
                end else if (slot_end_c) begin
                    state_d  = S_FIN;
                    status_d = ST_UNDERRUN;
                end
            end
            S_TX: begin
                if (slot_end_c) begin
                    bits_d = bits_q - 10'd1;
                    if (bits_q == 10'd1) begin
                        state_d = S_GUARD;
                    end else if (bitidx_q == 3'd7) begin
                        // Byte boundary: the refill handshake lands on this slot's last cycle
                        if (tx_ready_q && bus.tx_valid) begin
                            shreg_d   = bus.tx_data;
                            bitidx_d  = 3'd0;
                            mod_sig_d = bus.tx_data[0];
                        end else begin
                            state_d  = S_FIN;
                            status_d = ST_UNDERRUN;
                        end
                    end else begin
                        shreg_d   = shreg_q >> 1;
                        bitidx_d  = bitidx_q + 3'd1;
                        mod_sig_d = shreg_q[1];
                    end
                end
            end
            S_GUARD: begin
                if (cfg_guard_q == 8'd0) begin
                    state_d = S_LISTEN;
                end else if (slot_end_c) begin
                    if (guard_cnt_q == cfg_guard_q - 8'd1) state_d = S_LISTEN;
                    else guard_cnt_d = guard_cnt_q + 8'd1;
                end
            end
            S_LISTEN: begin
                // A zero timeout wraps to 4095 here, giving the full 4096-slot window
                if (slot_end_c) begin
                    if (bus.curbit) begin
                        state_d        = S_RX;
                        rx_bit_d       = 1'b1;
                        rx_bit_valid_d = 1'b1;
                    end else if (to_cnt_q == cfg_to_q - 12'd1) begin
                        state_d  = S_FIN;
                        status_d = ST_TIMEOUT;
                    end else begin
                        to_cnt_d = to_cnt_q + 12'd1;
                    end
                end
            end
            S_RX: begin
                if (slot_end_c) begin
                    rx_bit_d       = bus.curbit;
                    rx_bit_valid_d = 1'b1;
                    if (bus.curbit) begin
                        zrun_d = '0;
                    end else if (zrun_q + ZR_W'(1) == ZR_END) begin
                        state_d  = S_FIN;
                        status_d = ST_OK;
                    end else begin
                        zrun_d = zrun_q + ZR_W'(1);
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d != state_q) begin
            phase_d     = '0;
            guard_cnt_d = '0;
            to_cnt_d    = '0;
            zrun_d      = '0;
        end else begin
            phase_d = slot_end_c ? '0 : phase_q + PH_W'(1);
        end

        unique case (state_d)
            S_TX:                     mod_type_d = MT_MOD;
            S_GUARD, S_LISTEN, S_RX:  mod_type_d = MT_LISTEN;
            default:                  mod_type_d = MT_OFF;
        endcase

        if (state_d != S_TX) mod_sig_d = 1'b0;

        tx_ready_d = (state_d == S_LOAD) ||
                     ((state_d == S_TX) && (phase_d == PH_LAST) &&
                      (bitidx_d == 3'd7) && (bits_d > 10'd1));
        busy_d = (state_d != S_IDLE) && (state_d != S_FIN);
        done_d = (state_d == S_FIN);
    end

    // State and output registers
    always_ff @(posedge osc_clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            phase_q        <= '0;
            bits_q         <= '0;
            shreg_q        <= '0;
            bitidx_q       <= '0;
            guard_cnt_q    <= '0;
            to_cnt_q       <= '0;
            zrun_q         <= '0;
            cfg_guard_q    <= '0;
            cfg_to_q       <= '0;
            tx_ready_q     <= 1'b0;
            mod_type_q     <= MT_OFF;
            mod_sig_q      <= 1'b0;
            rx_bit_q       <= 1'b0;
            rx_bit_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            status_q       <= ST_OK;
        end else begin
            state_q        <= state_d;
            phase_q        <= phase_d;
            bits_q         <= bits_d;
            shreg_q        <= shreg_d;
            bitidx_q       <= bitidx_d;
            guard_cnt_q    <= guard_cnt_d;
            to_cnt_q       <= to_cnt_d;
            zrun_q         <= zrun_d;
            cfg_guard_q    <= cfg_guard_d;
            cfg_to_q       <= cfg_to_d;
            tx_ready_q     <= tx_ready_d;
            mod_type_q     <= mod_type_d;
            mod_sig_q      <= mod_sig_d;
            rx_bit_q       <= rx_bit_d;
            rx_bit_valid_q <= rx_bit_valid_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            status_q       <= status_d;
        end
    end

    assign bus.tx_ready     = tx_ready_q;
    assign bus.mod_type     = mod_type_q;
    assign bus.mod_sig      = mod_sig_q;
    assign bus.rx_bit       = rx_bit_q;
    assign bus.rx_bit_valid = rx_bit_valid_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.status       = status_q;
endmodule

// File: tb/tb_hf_reader_sequencer.sv
// Directed bench for hf_reader_sequencer: table of whole transactions plus hand-written
// sequences for LOAD underrun, start-while-busy and mid-transaction reset.
module tb_hf_reader_sequencer;
    localparam int END_SLOTS = 2;

    typedef struct {
        logic [9:0]  len;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic        v1;
        logic [7:0]  guard;
        logic [11:0] to;
        logic [31:0] curbits;
        int          ncur;
        logic [15:0] exp_mod;
        logic [1:0]  exp_status;
        int          exp_rx;
        int          restart_slot;
    } vec_t;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    int   rx_pulses;
    int   done_pulses;
    vec_t vecs [5];

    hf_reader_sequencer_if bus ();

    hf_reader_sequencer #(.SLOT_TICKS(16), .END_SLOTS(END_SLOTS)) dut (
        .osc_clk (clk),
        .reset   (reset),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.rx_bit_valid === 1'b1) rx_pulses <= rx_pulses + 1;
        if (bus.done === 1'b1) done_pulses <= done_pulses + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int id, input vec_t v);
        int    n_tx, zeros, to_cnt, limit, rx0, dn0;
        bit    fin, in_rx, emit, cb;
        string tag;
        tag = $sformatf("v%0d", id);
        rx0 = rx_pulses;
        dn0 = done_pulses;
        bus.start = 1'b1; bus.tx_len = v.len; bus.guard_slots = v.guard;
        bus.rx_timeout = v.to; bus.tx_data = v.b0; bus.tx_valid = 1'b1;
        cyc(1);
        bus.start = 1'b0; bus.tx_len = 10'd0; bus.guard_slots = 8'hFF; bus.rx_timeout = 12'd1;
        chk({tag, " load busy"}, bus.busy, 1);
        chk({tag, " load tx_ready"}, bus.tx_ready, 1);
        chk({tag, " load mod_type"}, bus.mod_type, 3'b000);
        cyc(1);
        chk({tag, " tx mod_type"}, bus.mod_type, 3'b100);
        chk({tag, " tx ready low"}, bus.tx_ready, 0);
        bus.tx_data = v.b1; bus.tx_valid = v.v1;
        n_tx = (v.exp_status == 2'd2) ? 8 : int'(v.len);
        for (int i = 0; i < n_tx; i++) begin
            cyc(8);
            chk($sformatf("%s mod_sig slot%0d", tag, i), bus.mod_sig, v.exp_mod[i]);
            if (i == v.restart_slot) begin
                bus.start = 1'b1; bus.tx_len = 10'd3;
                cyc(1);
                bus.start = 1'b0;
                cyc(6);
            end else begin
                cyc(7);
            end
            chk($sformatf("%s tx_ready slot%0d", tag, i), bus.tx_ready,
                32'((i % 8 == 7) && (i + 1 < int'(v.len))));
            cyc(1);
        end
        bus.tx_valid = 1'b0;
        if (v.exp_status == 2'd2) begin
            chk({tag, " underrun done"}, bus.done, 1);
            chk({tag, " underrun status"}, bus.status, 2);
            chk({tag, " underrun mod_sig"}, bus.mod_sig, 0);
            chk({tag, " underrun mod_type"}, bus.mod_type, 3'b000);
            chk({tag, " underrun busy"}, bus.busy, 0);
        end else begin
            chk({tag, " guard mod_type"}, bus.mod_type, 3'b011);
            chk({tag, " guard mod_sig"}, bus.mod_sig, 0);
            cyc((v.guard == 8'd0) ? 1 : 16 * int'(v.guard));
            chk({tag, " listen busy"}, bus.busy, 1);
            limit = (v.to == 12'd0) ? 4096 : int'(v.to);
            fin = 0; in_rx = 0; zeros = 0; to_cnt = 0;
            for (int k = 0; k < v.ncur && !fin; k++) begin
                cb = v.curbits[k];
                bus.curbit = cb;
                cyc(16);
                emit = 0;
                if (!in_rx) begin
                    if (cb) begin in_rx = 1; emit = 1; end
                    else begin to_cnt++; if (to_cnt == limit) fin = 1; end
                end else begin
                    emit = 1;
                    if (cb) zeros = 0;
                    else begin zeros++; if (zeros == END_SLOTS) fin = 1; end
                end
                chk($sformatf("%s rx_valid slot%0d", tag, k), bus.rx_bit_valid, 32'(emit));
                if (emit) chk($sformatf("%s rx_bit slot%0d", tag, k), bus.rx_bit, 32'(cb));
                chk($sformatf("%s done slot%0d", tag, k), bus.done, 32'(fin));
                if (fin) begin
                    chk({tag, " status"}, bus.status, v.exp_status);
                    chk({tag, " fin busy"}, bus.busy, 0);
                    chk({tag, " fin mod_type"}, bus.mod_type, 3'b000);
                end else begin
                    chk($sformatf("%s rx mod_type slot%0d", tag, k), bus.mod_type, 3'b011);
                end
            end
            bus.curbit = 1'b0;
            chk({tag, " frame ended"}, 32'(fin), 1);
        end
        cyc(1);
        chk({tag, " done one cycle"}, bus.done, 0);
        chk({tag, " status held"}, bus.status, v.exp_status);
        cyc(1);
        chk({tag, " rx pulse count"}, rx_pulses - rx0, v.exp_rx);
        chk({tag, " done pulse count"}, done_pulses - dn0, 1);
    endtask

    initial begin
        int dn0;
        n_tests = 0; n_fail = 0; rx_pulses = 0; done_pulses = 0;
        reset = 1'b1;
        bus.start = 1'b0; bus.tx_len = '0; bus.guard_slots = '0; bus.rx_timeout = '0;
        bus.tx_data = '0; bus.tx_valid = 1'b0; bus.curbit = 1'b0;

        //                len     b0     b1     v1 guard  to      curbits       ncur exp_mod  st  rx restart
        vecs[0] = '{10'd7,  8'h26, 8'h00, 1'b1, 8'd2, 12'd10, 32'h0000_000D, 6,  16'h0026, 2'd0, 6, -1};
        vecs[1] = '{10'd16, 8'hA5, 8'h00, 1'b0, 8'd1, 12'd5,  32'h0000_0000, 0,  16'h00A5, 2'd2, 0, -1};
        vecs[2] = '{10'd3,  8'h05, 8'h00, 1'b1, 8'd1, 12'd5,  32'h0000_0000, 5,  16'h0005, 2'd1, 0, -1};
        vecs[3] = '{10'd12, 8'h3C, 8'h09, 1'b1, 8'd0, 12'd3,  32'h0000_002C, 8,  16'h093C, 2'd0, 6,  2};
        vecs[4] = '{10'd1,  8'h01, 8'h00, 1'b1, 8'd0, 12'd0,  32'h0010_0000, 23, 16'h0001, 2'd0, 3, -1};

        cyc(3);
        chk("reset mod_type", bus.mod_type, 0);
        chk("reset mod_sig", bus.mod_sig, 0);
        chk("reset tx_ready", bus.tx_ready, 0);
        chk("reset rx_bit", bus.rx_bit, 0);
        chk("reset rx_bit_valid", bus.rx_bit_valid, 0);
        chk("reset busy", bus.busy, 0);
        chk("reset done", bus.done, 0);
        chk("reset status", bus.status, 0);
        reset = 1'b0;
        cyc(2);

        for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

        // tx_valid never arrives in LOAD: one slot of waiting, then underrun
        bus.start = 1'b1; bus.tx_len = 10'd8; bus.guard_slots = 8'd1; bus.rx_timeout = 12'd5;
        bus.tx_valid = 1'b0;
        cyc(1);
        bus.start = 1'b0;
        chk("load wait tx_ready", bus.tx_ready, 1);
        cyc(15);
        chk("load wait done early", bus.done, 0);
        chk("load wait busy", bus.busy, 1);
        cyc(1);
        chk("load underrun done", bus.done, 1);
        chk("load underrun status", bus.status, 2);
        chk("load underrun busy", bus.busy, 0);
        chk("load underrun tx_ready", bus.tx_ready, 0);
        cyc(2);

        // Reset in TX slot 3 aborts silently; reset beats a simultaneous start
        bus.start = 1'b1; bus.tx_len = 10'd16; bus.tx_data = 8'hFF; bus.tx_valid = 1'b1;
        cyc(1);
        bus.start = 1'b0;
        cyc(1);
        cyc(16 * 3 + 5);
        chk("abort pre mod_type", bus.mod_type, 3'b100);
        chk("abort pre mod_sig", bus.mod_sig, 1);
        dn0 = done_pulses;
        reset = 1'b1;
        cyc(1);
        chk("abort mod_type", bus.mod_type, 0);
        chk("abort busy", bus.busy, 0);
        chk("abort mod_sig", bus.mod_sig, 0);
        chk("abort tx_ready", bus.tx_ready, 0);
        chk("abort done", bus.done, 0);
        bus.start = 1'b1;
        cyc(1);
        bus.start = 1'b0; reset = 1'b0; bus.tx_valid = 1'b0;
        cyc(1);
        chk("reset over start busy", bus.busy, 0);
        cyc(20);
        chk("abort no done", done_pulses - dn0, 0);
        run_vec(10, vecs[0]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
